// File: rtl/serial_latch_receiver_pkg.sv
// rtl/serial_latch_receiver_pkg.sv - shared types and constants for the serial/latch link receiver
package serial_latch_receiver_pkg;

  // Frame width used by the LED, DIP and receiver blocks on this link
  localparam int DEFAULT_FRAME_WIDTH = 16;

  // Receiver states: waiting for first latch, collecting bits, idle between frames
  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } rx_state_t;

  // Counter must reach WIDTH+1 (overlong marker) without wrapping
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/serial_latch_receiver.sv
// rtl/serial_latch_receiver.sv - deserialises strobed frames and commits them on the latch strobe
module serial_latch_receiver
  import serial_latch_receiver_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_FRAME_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic             i_EN,
  input  logic             i_Data,
  input  logic             i_Latch,
  output logic [WIDTH-1:0] o_Data,
  output logic             o_Valid,
  output logic             o_FrameErr,
  output logic             o_Synced
);

  localparam int CW = cnt_width(WIDTH);
  // Good frame count, and the saturating "overlong" value one above it
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);

  rx_state_t        state_q, state_nxt;
  logic [WIDTH-1:0] shift_q, shift_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic             valid_q, valid_nxt;
  logic             err_q, err_nxt;
  logic             synced_q, synced_nxt;

  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt_inc;

  // Shift register with the incoming bit inserted at the end opposite the first-received bit
  assign shifted = MSB_FIRST ? {shift_q[WIDTH-2:0], i_Data} : {i_Data, shift_q[WIDTH-1:1]};
  // Saturate so an overlong frame can never wrap back to a good count
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  // State and datapath registers; reset discards any partial frame
  always_ff @(posedge i_CLK) begin
    if (!i_RESET) begin
      state_q  <= SYNC;
      shift_q  <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      synced_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      shift_q  <= shift_nxt;
      cnt_q    <= cnt_nxt;
      data_q   <= data_nxt;
      valid_q  <= valid_nxt;
      err_q    <= err_nxt;
      synced_q <= synced_nxt;
    end
  end

  // Next-state and datapath decisions, evaluated only on strobed cycles
  always_comb begin
    state_nxt  = state_q;
    shift_nxt  = shift_q;
    cnt_nxt    = cnt_q;
    data_nxt   = data_q;
    valid_nxt  = 1'b0;
    err_nxt    = err_q;
    synced_nxt = synced_q;
    if (i_EN) begin
      case (state_q)
        SYNC: begin
          // Data before the first latch has unknown alignment, so it is dropped
          if (i_Latch) begin
            state_nxt  = HOLD;
            synced_nxt = 1'b1;
          end
        end
        SHIFT: begin
          if (!i_Latch) begin
            shift_nxt = shifted;
            cnt_nxt   = cnt_inc;
          end else begin
            if (cnt_q == CNT_FULL) begin
              data_nxt  = shift_q;
              valid_nxt = 1'b1;
              err_nxt   = 1'b0;
            end else begin
              err_nxt = 1'b1;
            end
            cnt_nxt   = '0;
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          // Repeated latch strobes are ignored; the first data bit opens the next frame
          if (!i_Latch) begin
            shift_nxt = shifted;
            cnt_nxt   = CW'(1);
            state_nxt = SHIFT;
          end
        end
        default: begin
          state_nxt = SYNC;
        end
      endcase
    end
  end

  assign o_Data     = data_q;
  assign o_Valid    = valid_q;
  assign o_FrameErr = err_q;
  assign o_Synced   = synced_q;

endmodule

// File: tb/tb_serial_latch_receiver.sv
// tb/tb_serial_latch_receiver.sv - self-checking bench for serial_latch_receiver
module tb_serial_latch_receiver;

  localparam int WIDTH = 16;

  logic             i_CLK = 1'b0;
  logic             i_RESET = 1'b0;
  logic             i_EN = 1'b0;
  logic             i_Data = 1'b0;
  logic             i_Latch = 1'b0;
  logic [WIDTH-1:0] o_Data;
  logic             o_Valid;
  logic             o_FrameErr;
  logic             o_Synced;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  serial_latch_receiver #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
    .i_CLK(i_CLK),
    .i_RESET(i_RESET),
    .i_EN(i_EN),
    .i_Data(i_Data),
    .i_Latch(i_Latch),
    .o_Data(o_Data),
    .o_Valid(o_Valid),
    .o_FrameErr(o_FrameErr),
    .o_Synced(o_Synced)
  );

  always #5 i_CLK = ~i_CLK;

  // Reference model: a link is a sequence of strobed symbols (bit or latch).
  // Once aligned, the bits collected since the previous latch form a frame;
  // exactly WIDTH of them commit, any other non-zero count is an error.
  bit               m_synced = 1'b0;
  bit               m_valid = 1'b0;
  bit               m_err = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  bit               m_bits[$];

  always @(posedge i_CLK) begin
    logic [WIDTH-1:0] v;
    m_valid = 1'b0;
    if (!i_RESET) begin
      m_synced = 1'b0;
      m_err    = 1'b0;
      m_data   = '0;
      m_bits.delete();
    end else if (i_EN) begin
      if (!i_Latch) begin
        if (m_synced) m_bits.push_back(i_Data);
      end else if (!m_synced) begin
        m_synced = 1'b1;
      end else if (m_bits.size() != 0) begin
        if (m_bits.size() == WIDTH) begin
          v = '0;
          foreach (m_bits[k]) v = (v << 1) | WIDTH'(m_bits[k]);
          m_data  = v;
          m_valid = 1'b1;
          m_err   = 1'b0;
        end else begin
          m_err = 1'b1;
        end
        m_bits.delete();
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge i_CLK) begin
    if (chk_en) begin
      check("model_data", 32'(o_Data), 32'(m_data));
      check("model_valid", 32'(o_Valid), 32'(m_valid));
      check("model_err", 32'(o_FrameErr), 32'(m_err));
      check("model_synced", 32'(o_Synced), 32'(m_synced));
    end
  end

  // Idle cycles with junk on data/latch, which must be ignored while i_EN=0
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      i_EN    = 1'b0;
      i_Data  = 1'($urandom_range(0, 1));
      i_Latch = 1'($urandom_range(0, 1));
      @(posedge i_CLK);
      #1;
    end
  endtask

  task automatic strobe(input logic d, input logic l);
    i_EN    = 1'b1;
    i_Data  = d;
    i_Latch = l;
    @(posedge i_CLK);
    #1;
    i_EN    = 1'b0;
    i_Latch = 1'b0;
  endtask

  // Send nbits of value, most significant first, with gap idle cycles after each bit
  task automatic send_bits(input logic [31:0] value, input int nbits, input int gap);
    for (int i = nbits - 1; i >= 0; i--) begin
      strobe(value[i], 1'b0);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic do_reset();
    i_RESET = 1'b0;
    i_EN    = 1'b0;
    @(posedge i_CLK);
    #1;
    @(posedge i_CLK);
    #1;
    i_RESET = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();
    chk_en = 1'b1;
    check("reset_data", 32'(o_Data), 32'h0);
    check("reset_valid", 32'(o_Valid), 32'h0);
    check("reset_err", 32'(o_FrameErr), 32'h0);
    check("reset_synced", 32'(o_Synced), 32'h0);

    // Unaligned frame is dropped; first latch only aligns
    send_bits(32'hA5C3, 16, 0);
    check("presync_synced", 32'(o_Synced), 32'h0);
    strobe(1'b0, 1'b1);
    check("sync_synced", 32'(o_Synced), 32'h1);
    check("sync_data", 32'(o_Data), 32'h0);
    check("sync_valid", 32'(o_Valid), 32'h0);

    // Good frame, back-to-back with the alignment latch
    send_bits(32'h1234, 16, 0);
    strobe(1'b0, 1'b1);
    check("good_data", 32'(o_Data), 32'h1234);
    check("good_valid", 32'(o_Valid), 32'h1);
    check("good_err", 32'(o_FrameErr), 32'h0);
    idle(1);
    check("good_valid_pulse", 32'(o_Valid), 32'h0);

    // Short frame then recovery
    send_bits(32'h7FFF, 15, 0);
    strobe(1'b0, 1'b1);
    check("short_err", 32'(o_FrameErr), 32'h1);
    check("short_data_hold", 32'(o_Data), 32'h1234);
    check("short_valid", 32'(o_Valid), 32'h0);
    send_bits(32'hFFFF, 16, 0);
    strobe(1'b0, 1'b1);
    check("ffff_data", 32'(o_Data), 32'hFFFF);
    check("ffff_err", 32'(o_FrameErr), 32'h0);

    // Overlong frame must not alias to a good count
    send_bits(32'hABCDE, 20, 0);
    strobe(1'b0, 1'b1);
    check("long_err", 32'(o_FrameErr), 32'h1);
    check("long_data_hold", 32'(o_Data), 32'hFFFF);

    // Latch held for three strobes evaluates once
    send_bits(32'h00FF, 16, 0);
    strobe(1'b0, 1'b1);
    check("hold_l1_valid", 32'(o_Valid), 32'h1);
    check("hold_l1_data", 32'(o_Data), 32'h00FF);
    strobe(1'b0, 1'b1);
    check("hold_l2_valid", 32'(o_Valid), 32'h0);
    strobe(1'b0, 1'b1);
    check("hold_l3_valid", 32'(o_Valid), 32'h0);
    check("hold_l3_err", 32'(o_FrameErr), 32'h0);

    // Sparse strobing, 1 of 4 cycles
    send_bits(32'h8001, 16, 3);
    strobe(1'b0, 1'b1);
    check("sparse_data", 32'(o_Data), 32'h8001);
    check("sparse_valid", 32'(o_Valid), 32'h1);

    // Reset mid-frame discards everything and drops alignment
    send_bits(32'h5A, 8, 0);
    do_reset();
    check("midrst_data", 32'(o_Data), 32'h0);
    check("midrst_synced", 32'(o_Synced), 32'h0);
    send_bits(32'hC3, 8, 0);
    strobe(1'b0, 1'b1);
    check("midrst_after_data", 32'(o_Data), 32'h0);
    check("midrst_after_valid", 32'(o_Valid), 32'h0);
    check("midrst_after_synced", 32'(o_Synced), 32'h1);

    // Randomised frames: mostly full length, some short/long, random stalls and resets
    for (int f = 0; f < 300; f++) begin
      int len;
      int nl;
      logic [31:0] val;
      len = ($urandom_range(0, 9) < 6) ? WIDTH : int'($urandom_range(1, 22));
      val = $urandom;
      for (int i = len - 1; i >= 0; i--) begin
        strobe(val[i], 1'b0);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        if ($urandom_range(0, 399) == 0) do_reset();
      end
      nl = int'($urandom_range(1, 3));
      for (int j = 0; j < nl; j++) begin
        strobe(1'b0, 1'b1);
        if ($urandom_range(0, 2) == 0) idle(1);
      end
    end

    idle(2);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_latch_receiver.md
Name: serial_latch_receiver

Overview:
- Responder end of the board's serial-data/latch link, the same link the LED and 7-segment drivers transmit on.
- Deserialises a WIDTH-bit frame strobed by i_EN and commits it to a parallel register on the latch strobe.
- Used on-chip as a loopback model of the LED shift chain for self-test, and to receive frames from a second board.
- Adds frame alignment after reset and detection of short or long frames.

Parameters:
- WIDTH, 16: frame length in bits.
- MSB_FIRST, 1: 1 = first bit received lands in o_Data[WIDTH-1]; 0 = first bit lands in o_Data[0].

Ports:
- i_CLK  input  1  system clock; all logic on its rising edge.
- i_RESET  input  1  synchronous, active-low reset.
- i_EN  input  1  bit strobe; i_Data and i_Latch are sampled only on cycles with i_EN=1.
- i_Data  input  1  serial data bit.
- i_Latch  input  1  commit strobe; a strobed cycle with i_Latch=1 carries no data bit.
- o_Data  output  WIDTH  last committed frame.
- o_Valid  output  1  one-cycle pulse when o_Data updates.
- o_FrameErr  output  1  high after a latch with wrong bit count; cleared by the next good commit.
- o_Synced  output  1  high once frame alignment is acquired.

Behaviour:
- Reset (i_RESET=0 at a clock edge):
  - o_Data=0, o_Valid=0, o_FrameErr=0, o_Synced=0.
  - Shift register=0, bit counter=0, state=SYNC.
  - Reset overrides every other input. Reset mid-frame discards the partial frame.
- Cycles with i_EN=0 (stall): no state change; o_Valid=0.
- Bit counter: range 0..WIDTH+1; saturates at WIDTH+1, which means "overlong".
- State SYNC:
  - Strobed data bits are ignored.
  - A strobed i_Latch=1 goes to HOLD, sets o_Synced=1 and does not commit.
- State SHIFT:
  - Strobed i_Latch=0: shift i_Data in and increment the counter (saturating).
  - MSB_FIRST=1: shift left and insert at bit 0. MSB_FIRST=0: shift right and insert at bit WIDTH-1.
  - Strobed i_Latch=1, counter==WIDTH: o_Data<=shift register, o_Valid=1 for exactly one cycle, o_FrameErr<=0.
  - Strobed i_Latch=1, counter!=WIDTH (short or overlong): o_Data holds, o_Valid=0, o_FrameErr<=1.
  - After either latch outcome: counter<=0 and state goes to HOLD.
- State HOLD:
  - Further strobed i_Latch=1 cycles are ignored: no commit, no error.
  - The first strobed i_Latch=0 is the first data bit of the next frame. It is shifted in, counter<=1, state goes to SHIFT.
- Latency: o_Data and o_Valid are registered and visible the cycle after the committing strobe edge.
- Shift register contents are not cleared on commit. Stale bits are shifted out by a full-length frame.
- The WIDTH+1 saturation prevents a wrapped counter from aliasing to a good count.
- Back-to-back frames with no idle strobes are supported: latch, then the next bit on the very next strobe.
- o_FrameErr is level-sticky until the next good commit or reset.

Decomposition:
- Shared package:
  - State encoding enum: SYNC, SHIFT, HOLD (2 bits).
  - Default frame width constant (16), shared with the LED and DIP blocks.
  - Counter-width function: clog2(WIDTH+2).
- Single module. No sub-module needed; the shift register and counter are trivially inline.

Test Plan:
- Reset then 16 bits of 0xA5C3 (MSB first) with no prior latch -> ignored, o_Synced=0. Then latch -> o_Synced=1, o_Data=0, o_Valid=0.
- Synced; send 0x1234 MSB first then latch -> o_Data=0x1234 next cycle, o_Valid high exactly 1 cycle, o_FrameErr=0.
- Send 15 bits then latch -> o_FrameErr=1, o_Data holds 0x1234. Then a full frame 0xFFFF + latch -> o_Data=0xFFFF, o_FrameErr=0.
- Send 20 bits then latch -> o_FrameErr=1 (saturation, no alias). Latch held high 3 strobes -> single evaluation, no extra o_Valid.
- i_EN toggled 1-of-4 cycles during frame 0x8001 -> same result as continuous strobing. Stalls insert no bits.
- i_RESET=0 after 8 bits of a frame -> all outputs 0, state SYNC. The remaining 8 bits + latch -> no commit, o_Synced=1 only.
